// File: rtl/pop_quiz.sv
// pop_quiz: Moore detector for the serial pattern "110" on d_in.
// Runs of two or more 1s followed by a 0 give exactly one one-cycle pulse on a.
// A 1 sampled in the match state counts as the first 1 of the next pattern.
module pop_quiz (
    input  logic clk,
    input  logic reset,
    input  logic d_in,
    output logic a
);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,  // no progress
        StSeen1  = 2'b01,  // seen "1"
        StSeen11 = 2'b10,  // seen "11" (holds on further 1s)
        StMatch  = 2'b11   // seen "110"
    } state_e;

    state_e state_q;
    state_e state_d;

    // State register; reset forces idle immediately, independent of clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic on the sampled bit.
    always_comb begin
        state_d = StIdle;
        unique case (state_q)
            StIdle:   state_d = d_in ? StSeen1  : StIdle;
            StSeen1:  state_d = d_in ? StSeen11 : StIdle;
            StSeen11: state_d = d_in ? StSeen11 : StMatch;
            StMatch:  state_d = d_in ? StSeen1  : StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Output is a pure decode of the state register, so no path from d_in.
    always_comb begin
        a = 1'b0;
        if (state_q == StMatch) begin
            a = 1'b1;
        end
    end

endmodule

// File: tb/tb_pop_quiz.sv
// Self-checking bench for pop_quiz. The reference model keeps the last three
// sampled bits since reset; a match is expected whenever they read "110".
module tb_pop_quiz;

    logic clk;
    logic reset;
    logic d_in;
    logic a;

    int n_checks;
    int n_fails;
    int step_no;

    logic [2:0] hist;
    logic       exp_q[$];

    pop_quiz dut (
        .clk   (clk),
        .reset (reset),
        .d_in  (d_in),
        .a     (a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if the run ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: a=%b, expected %b", tag, obs, exp);
        end
    endtask

    // Drive one bit after the falling edge, queue the expected flag, and
    // compare it just after the rising edge that samples the bit.
    task automatic drive_bit(input logic b);
        logic exp;
        @(negedge clk);
        d_in = b;
        hist = {hist[1:0], b};
        exp_q.push_back(hist == 3'b110);
        @(posedge clk);
        #1;
        step_no++;
        exp = exp_q.pop_front();
        check($sformatf("step%0d", step_no), a, exp);
    endtask

    task automatic drive_seq(input logic [15:0] bits, input int len);
        for (int i = len - 1; i >= 0; i--) begin
            drive_bit(bits[i]);
        end
    endtask

    task automatic pulse_reset_async(input string tag);
        @(negedge clk);
        #1;
        reset = 1'b1;
        hist  = 3'b000;
        #1;
        check(tag, a, 1'b0);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        step_no  = 0;
        hist     = 3'b000;
        d_in     = 1'b0;
        reset    = 1'b1;

        // Reset state before any clock edge.
        #2;
        check("reset_pre_clk", a, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", a, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // 1,1,1,0,0,1,1,0,0,0: pulses after bit 4 and bit 8.
        drive_seq(16'b1110011000, 10);

        // 1,0,1,0,0: isolated 1s never match.
        drive_seq(16'b10100, 5);

        // Overlap 1,1,0,1,1,0: pulses after bit 3 and bit 6.
        drive_seq(16'b110110, 6);
        drive_bit(1'b0);

        // Eight 1s then 0: single pulse after the 0.
        drive_seq(16'b111111110, 9);
        drive_bit(1'b0);

        // Reset with progress in the "11" state; the following 0 must not match.
        drive_seq(16'b11, 2);
        pulse_reset_async("reset_in_s2");
        drive_bit(1'b0);

        // Reset while the match flag is high; flag drops without a clock edge.
        drive_seq(16'b110, 3);
        check("flag_before_reset", a, 1'b1);
        pulse_reset_async("reset_in_s3");
        drive_bit(1'b0);
        drive_bit(1'b0);

        // State must be idle after that reset: one 1 then 0 is not a match,
        // and a fresh 1,1,0 is.
        drive_seq(16'b10, 2);
        drive_seq(16'b110, 3);
        drive_bit(1'b1);
        drive_bit(1'b0);

        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pop_quiz.md
Name: pop_quiz

Overview:
- Moore finite-state machine that detects the serial bit pattern "1-1-0" on a single-bit input stream.
- When the pattern completes, it raises a one-cycle flag `a`.
- Small control primitive for serial-pattern recognition; used as a standalone leaf block clocked by the system clock.
- Overlapping detection is supported: a run of two or more 1s followed by a 0 counts as one match.

Parameters:
- None. Fixed single-bit input and output; state encoding is internal (2-bit binary).

Ports:
- clk    input   1  system clock; all state updates on the rising edge
- reset  input   1  asynchronous, active-high reset
- d_in   input   1  serial data bit, sampled on each rising edge of clk
- a      output  1  match flag; high for one cycle after "110" completes

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk, reset).
- Reset:
  - While reset = 1, state = S0 and a = 0 immediately, independent of clk.
  - On release, the first rising edge with reset = 0 samples d_in normally.
- States (2-bit register):
  - S0 idle/no progress (00)
  - S1 seen "1" (01)
  - S2 seen "11" (10)
  - S3 seen "110", match (11)
- Transitions on rising clk, based on sampled d_in:
  - S0: d_in = 1 -> S1; d_in = 0 -> S0
  - S1: d_in = 1 -> S2; d_in = 0 -> S0
  - S2: d_in = 1 -> S2 (a run of 1s holds); d_in = 0 -> S3
  - S3: d_in = 1 -> S1 (overlap restart); d_in = 0 -> S0
- Output (Moore): a = 1 iff state = S3.
  - a is a pure decode of the state register: glitch-free, no combinational path from d_in.
- Latency: a rises on the same rising edge that samples the terminating 0 (visible after that edge). It lasts exactly one clock period unless reset intervenes.
- Every "11…10" run produces exactly one pulse, regardless of run length ≥ 2.
- A single isolated 1 followed by 0 never produces a pulse.
- Reset mid-operation (any state, including S3): a drops to 0 asynchronously. Partial progress is discarded; the pattern must restart from S0.
- Unreachable or illegal encodings do not exist (all 4 codes are used). The default branch of next-state logic goes to S0.
- d_in must be stable around the rising edge; the driver changes it after the edge.

Test Plan:
- Reset then stream d_in = 1,1,1,0,0,1,1,0,0,0 (one bit per edge) -> a = 1 exactly in the cycle after the 4th sampled bit and after the 8th sampled bit; 0 elsewhere (two pulses total).
- Stream 1,0,1,0,0 -> a stays 0 throughout.
- Overlap stream 1,1,0,1,1,0 -> a pulses after the 3rd and the 6th sampled bits (S3 -> S1 path exercised).
- Long run: eight 1s then 0 -> single one-cycle pulse after the 0; no pulse during the run.
- Reset mid-operation: after sampling 1,1 (state S2), assert reset between edges -> a = 0 immediately. Release reset, then sample 0 -> a stays 0.
- Reset while a = 1 (state S3) -> a falls to 0 without waiting for a clock edge. After release with d_in = 0, the state remains S0.
